// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: mul/div op encodings, ALU opcodes and sequencer states.
package mips_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 4'b1010;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate: y = en ? -x : x.
module muldiv_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  assign y = en ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine that borrows the EX-stage ALU for one add/sub per
// iteration and produces a registered 64-bit HI/LO result.
module alu_muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned       WIDTH   = XLEN,
  parameter int unsigned       LEN_OP  = ALU_OP_W,
  parameter logic [LEN_OP-1:0] ALU_ADD = LEN_OP'(ALU_OP_ADD),
  parameter logic [LEN_OP-1:0] ALU_SUB = LEN_OP'(ALU_OP_SUB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [WIDTH-1:0]  i_rs,
  input  logic [WIDTH-1:0]  i_rt,
  input  logic              i_flush,
  output logic [WIDTH-1:0]  o_alu_a,
  output logic [WIDTH-1:0]  o_alu_b,
  output logic [LEN_OP-1:0] o_alu_op,
  input  logic [WIDTH-1:0]  i_alu_result,
  output logic              o_busy,
  output logic              o_done,
  output logic [WIDTH-1:0]  o_hi,
  output logic [WIDTH-1:0]  o_lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  muldiv_state_e    state_q, state_d;
  muldiv_op_e       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rs_q, rs_d, rt_q, rt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // P_hi for multiply, R for divide
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // P_lo for multiply, Q for divide
  logic [WIDTH-1:0] mcand_q, mcand_d;     // M for multiply, D for divide
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic               is_div, is_signed;
  logic [WIDTH-1:0]   abs_rs, abs_rt, fix_quo, fix_rem, div_t, mul_s;
  logic [2*WIDTH-1:0] fix_prod;
  logic               mul_c, div_borrow, res_msb;

  assign is_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

  muldiv_negate #(.WIDTH(WIDTH)) u_abs_rs (
    .en (is_signed & rs_q[WIDTH-1]), .x (rs_q), .y (abs_rs)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_abs_rt (
    .en (is_signed & rt_q[WIDTH-1]), .x (rt_q), .y (abs_rt)
  );
  muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .en (~is_div & neg_quo_q), .x ({acc_hi_q, acc_lo_q}), .y (fix_prod)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .en (is_div & neg_quo_q), .x (acc_lo_q), .y (fix_quo)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .en (is_div & neg_rem_q), .x (acc_hi_q), .y (fix_rem)
  );

  // ALU operand drive; the ALU answers combinationally in the same cycle.
  assign div_t   = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
  assign res_msb = i_alu_result[WIDTH-1];

  always_comb begin
    o_alu_a  = '0;
    o_alu_b  = '0;
    o_alu_op = ALU_ADD;
    if (state_q == ST_ITER) begin
      o_alu_b = mcand_q;
      if (is_div) begin
        o_alu_a  = div_t;
        o_alu_op = ALU_SUB;
      end else begin
        o_alu_a = acc_hi_q;
      end
    end
  end

  // Carry out of P_hi + M and borrow out of t - D, rebuilt from the operand and result MSBs.
  assign mul_s      = acc_lo_q[0] ? i_alu_result : acc_hi_q;
  assign mul_c      = acc_lo_q[0] &
                      ((acc_hi_q[WIDTH-1] & mcand_q[WIDTH-1]) |
                       ((acc_hi_q[WIDTH-1] | mcand_q[WIDTH-1]) & ~res_msb));
  assign div_borrow = (~div_t[WIDTH-1] & mcand_q[WIDTH-1]) |
                      ((~div_t[WIDTH-1] | mcand_q[WIDTH-1]) & res_msb);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    mcand_d   = mcand_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (i_start) begin
          state_d = ST_PREP;
          op_d    = muldiv_op_e'(i_op);
          rs_d    = i_rs;
          rt_d    = i_rt;
        end
      end
      ST_PREP: begin
        cnt_d    = '0;
        acc_hi_d = '0;
        if (is_div && (rt_q == '0)) begin
          // Divide by zero skips ITER; FIX passes these through unchanged.
          state_d   = ST_FIX;
          acc_hi_d  = rs_q;
          acc_lo_d  = '1;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
        end else begin
          state_d   = ST_ITER;
          neg_quo_d = is_signed & (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
          neg_rem_d = is_signed & rs_q[WIDTH-1];
          acc_lo_d  = is_div ? abs_rs : abs_rt;
          mcand_d   = is_div ? abs_rt : abs_rs;
        end
      end
      ST_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = ST_FIX;
        if (is_div) begin
          if (acc_hi_q[WIDTH-1] | ~div_borrow) begin
            acc_hi_d = i_alu_result;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = div_t;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = {mul_c, mul_s[WIDTH-1:1]};
          acc_lo_d = {mul_s[0], acc_lo_q[WIDTH-1:1]};
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (is_div) begin
          hi_d = fix_rem;
          lo_d = fix_quo;
        end else begin
          {hi_d, lo_d} = fix_prod;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over start and over the FIX result write.
    if (i_flush) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d == ST_PREP) || (state_d == ST_ITER) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULTU;
      cnt_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mcand_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      mcand_q   <= mcand_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Scoreboard bench for alu_muldiv_sequencer with a behavioural stand-in for the EX-stage ALU.
module tb_alu_muldiv_sequencer;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_rs = '0;
  logic [31:0] i_rt = '0;
  logic        i_flush = 1'b0;
  logic [31:0] o_alu_a, o_alu_b, alu_result, o_hi, o_lo;
  logic [3:0]  o_alu_op;
  logic        o_busy, o_done;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always #5 clk = ~clk;

  assign alu_result = (o_alu_op == 4'b1010) ? (o_alu_a - o_alu_b) : (o_alu_a + o_alu_b);

  alu_muldiv_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_op         (i_op),
    .i_rs         (i_rs),
    .i_rt         (i_rt),
    .i_flush      (i_flush),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .i_alu_result (alu_result),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_hi         (o_hi),
    .o_lo         (o_lo)
  );

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint          sa, sb, sq, sr;
    longint unsigned p;
    exp_t            e;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    case (op)
      2'b00: begin p = {32'b0, rs} * {32'b0, rt}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = longint'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b10: begin
        if (rt == 0) begin e.hi = rs; e.lo = 32'hFFFFFFFF; end
        else begin e.hi = rs % rt; e.lo = rs / rt; end
      end
      default: begin
        if (rt == 0) begin e.hi = rs; e.lo = 32'hFFFFFFFF; end
        else begin sq = sa / sb; sr = sa % sb; e.hi = 32'(sr); e.lo = 32'(sq); end
      end
    endcase
    return e;
  endfunction

  // Drive a one-cycle start; returns just after the edge that samples it.
  task automatic start_op(input bit at_neg, input logic [1:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input bit push, input exp_t e);
    if (!at_neg) @(negedge clk);
    i_start = 1'b1; i_op = op; i_rs = rs; i_rt = rt;
    if (push) sb_q.push_back(e);
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  // Count edges after the start edge until o_done is seen; ends on a negedge.
  task automatic wait_done(input int budget, output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < budget) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      seen = o_done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({o_busy, o_done, o_hi, o_lo, o_alu_a, o_alu_b, o_alu_op} !== {2'b00, 128'b0, 4'b0011}) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b hi=%h lo=%h a=%h b=%h op=%b, want all 0, op=0011",
               o_busy, o_done, o_hi, o_lo, o_alu_a, o_alu_b, o_alu_op);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({o_busy, o_done, o_hi, o_lo} !== 66'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b done=%b hi=%h lo=%h, want all 0",
               o_busy, o_done, o_hi, o_lo);
    end
  endtask

  task automatic run_checked(input string name, input logic [1:0] op, input logic [31:0] rs,
                             input logic [31:0] rt, input exp_t e, input int lat);
    int   edges;
    bit   seen;
    exp_t got;
    start_op(1'b0, op, rs, rt, 1'b1, e);
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_after_start: got %b want 1", name, o_busy);
    end
    wait_done(60, edges, seen);
    vectors++;
    if (!seen || (lat > 0 && edges != lat)) begin
      miscompares++;
      $display("FAIL %s latency: got done=%b after %0d edges, want done after %0d", name, seen, edges, lat);
    end
    if (seen) begin
      got = sb_q.pop_front();
      vectors++;
      if (o_hi !== got.hi || o_lo !== got.lo) begin
        miscompares++;
        $display("FAIL %s result: got hi=%h lo=%h, want hi=%h lo=%h", name, o_hi, o_lo, got.hi, got.lo);
      end
      last_hi = got.hi;
      last_lo = got.lo;
      vectors++;
      if (o_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s busy_at_done: got %b want 0", name, o_busy);
      end
    end else begin
      void'(sb_q.pop_front());
    end
  endtask

  task automatic test_mul();
    run_checked("multu_7x6", 2'b00, 32'd7, 32'd6, '{32'h0, 32'd42}, 34);
    run_checked("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, '{32'hFFFFFFFE, 32'h00000001}, 34);
    run_checked("mult_m3x5", 2'b01, -32'sd3, 32'sd5, '{32'hFFFFFFFF, 32'hFFFFFFF1}, 34);
  endtask

  task automatic test_div();
    run_checked("div_m7d2", 2'b11, -32'sd7, 32'sd2, '{32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
    run_checked("divu_100d7", 2'b10, 32'd100, 32'd7, '{32'd2, 32'd14}, 34);
    run_checked("divu_5d0", 2'b10, 32'd5, 32'd0, '{32'd5, 32'hFFFFFFFF}, 2);
    run_checked("div_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, '{32'h0, 32'h80000000}, 34);
  endtask

  task automatic test_random();
    logic [31:0] rs, rt;
    logic [1:0]  op;
    for (int k = 0; k < 16; k++) begin
      op = 2'(k % 4);
      rs = $urandom;
      rt = (k >= 8) ? 32'($urandom_range(1, 255)) : $urandom;
      run_checked("random", op, rs, rt, model(op, rs, rt), 34);
    end
  endtask

  task automatic test_flush();
    int edges;
    bit seen;
    start_op(1'b0, 2'b00, 32'd12345, 32'd678, 1'b0, '0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk);
    #1 i_flush = 1'b0;
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_busy: got %b want 0", o_busy);
    end
    wait_done(40, edges, seen);
    vectors++;
    if (seen || o_hi !== last_hi || o_lo !== last_lo) begin
      miscompares++;
      $display("FAIL flush_no_done: got done=%b hi=%h lo=%h, want done=0 hi=%h lo=%h",
               seen, o_hi, o_lo, last_hi, last_lo);
    end
    run_checked("after_flush_3x3", 2'b00, 32'd3, 32'd3, '{32'h0, 32'd9}, 34);
  endtask

  task automatic test_start_while_busy();
    int edges;
    bit seen;
    run_checked("busy_ignores_start", 2'b00, 32'd1000, 32'd1000, '{32'h0, 32'd1000000}, 0);
    start_op(1'b0, 2'b01, 32'd1000, 32'd1000, 1'b1, '{32'h0, 32'd1000000});
    repeat (5) begin
      @(negedge clk);
      i_start = 1'b1; i_op = 2'b10; i_rs = 32'd9; i_rt = 32'd3;
    end
    @(negedge clk);
    i_start = 1'b0;
    wait_done(60, edges, seen);
    vectors++;
    if (!seen || o_hi !== sb_q[0].hi || o_lo !== sb_q[0].lo) begin
      miscompares++;
      $display("FAIL start_ignored_result: got done=%b hi=%h lo=%h, want done=1 hi=%h lo=%h",
               seen, o_hi, o_lo, sb_q[0].hi, sb_q[0].lo);
    end
    last_hi = sb_q[0].hi;
    last_lo = sb_q[0].lo;
    void'(sb_q.pop_front());
    wait_done(40, edges, seen);
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL start_ignored_extra_done: got done=1 after %0d edges, want no done", edges);
    end
  endtask

  task automatic test_back_to_back();
    int   edges;
    bit   seen;
    exp_t got;
    start_op(1'b0, 2'b01, 32'hFFFFFF00, 32'd77, 1'b1, model(2'b01, 32'hFFFFFF00, 32'd77));
    wait_done(60, edges, seen);
    got = sb_q.pop_front();
    vectors++;
    if (!seen || o_hi !== got.hi || o_lo !== got.lo) begin
      miscompares++;
      $display("FAIL b2b_first: got done=%b hi=%h lo=%h, want done=1 hi=%h lo=%h",
               seen, o_hi, o_lo, got.hi, got.lo);
    end
    start_op(1'b1, 2'b10, 32'd1000, 32'd33, 1'b1, '{32'd10, 32'd30});
    wait_done(60, edges, seen);
    got = sb_q.pop_front();
    vectors++;
    if (!seen || edges != 34 || o_hi !== got.hi || o_lo !== got.lo) begin
      miscompares++;
      $display("FAIL b2b_second: got done=%b edges=%0d hi=%h lo=%h, want done=1 edges=34 hi=%h lo=%h",
               seen, edges, o_hi, o_lo, got.hi, got.lo);
    end
    last_hi = got.hi;
    last_lo = got.lo;
  endtask

  task automatic test_reset_mid();
    int edges;
    bit seen;
    start_op(1'b0, 2'b11, 32'd5000, 32'd7, 1'b0, '0);
    repeat (21) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_busy, o_done, o_hi, o_lo, o_alu_a, o_alu_b, o_alu_op} !== {2'b00, 128'b0, 4'b0011}) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h a=%h b=%h op=%b, want all 0, op=0011",
               o_busy, o_done, o_hi, o_lo, o_alu_a, o_alu_b, o_alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(40, edges, seen);
    vectors++;
    if (seen || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_no_done: got done=%b busy=%b, want 0 0", seen, o_busy);
    end
    last_hi = '0;
    last_lo = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_random();
    test_flush();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
